// File: rtl/ls_winnower.sv
// ----------------------------------------------------------------------------
// ls_winnower
//
// Receive-side winnowing engine. It takes a stream of symbols in which each
// genuine message symbol is hidden among chaff. The stream is grouped into
// frames of LSLEN symbols, with one frame per genuine symbol. A latin-square
// key, latched when a message starts, gives the slot of the genuine symbol
// in each frame. The recovered MSG_BITS message is presented on a
// valid/ack handshake.
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a message (only honoured while idle)
//   key_square  in   packed square, entry [r][c] at ((r*LSLEN+c)*LSLENLOG)+:LSLENLOG
//   in_valid    in   stream symbol valid
//   in_data     in   stream symbol (genuine or chaff)
//   in_ready    out  engine accepts a symbol this cycle
//   msg_valid   out  recovered message available
//   msg_data    out  recovered message, symbol k at [k*LSLENLOG +: LSLENLOG]
//   msg_ack     in   consumer takes the message
//   busy        out  engine is loading, receiving or holding a result
// ----------------------------------------------------------------------------
module ls_winnower #(
    parameter int LSLEN    = 16,
    parameter int LSLENLOG = 4,
    parameter int MSG_BITS = 512
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [LSLEN*LSLEN*LSLENLOG-1:0]    key_square,
    input  logic                               in_valid,
    input  logic [LSLENLOG-1:0]                in_data,
    output logic                               in_ready,
    output logic                               msg_valid,
    output logic [MSG_BITS-1:0]                msg_data,
    input  logic                               msg_ack,
    output logic                               busy
);

    localparam int NSYM  = MSG_BITS / LSLENLOG;
    localparam int SYMW  = $clog2(NSYM);
    localparam int KIDXW = 2 * LSLENLOG;
    localparam int KEYW  = LSLEN * LSLEN * LSLENLOG;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RECV,
        S_DONE
    } state_t;

    state_t                 state_q;
    logic [KEYW-1:0]        key_q;
    logic [LSLENLOG-1:0]    slot_q;
    logic [SYMW-1:0]        sym_q;
    logic [MSG_BITS-1:0]    msg_q;
    logic                   in_ready_q;
    logic                   msg_valid_q;
    logic                   busy_q;

    logic                   accept;
    logic [KIDXW-1:0]       kidx;
    logic [LSLENLOG-1:0]    key_entry;
    logic                   genuine;
    logic                   slot_wrap;
    logic                   last_accept;
    logic [LSLENLOG-1:0]    slot_d;
    logic [SYMW-1:0]        sym_d;

    always_comb begin
        accept      = in_valid && in_ready_q;
        // Row is (sym/LSLEN)%LSLEN and column sym%LSLEN, so the flat square
        // index is simply sym modulo LSLEN*LSLEN: a width cast does both.
        kidx        = KIDXW'(sym_q);
        key_entry   = key_q[int'(kidx) * LSLENLOG +: LSLENLOG];
        genuine     = (slot_q == key_entry);
        slot_wrap   = (slot_q == LSLENLOG'(LSLEN - 1));
        last_accept = accept && slot_wrap && (sym_q == SYMW'(NSYM - 1));
        // Slot counter is exactly LSLENLOG bits, so it wraps LSLEN-1 -> 0 on its own.
        slot_d      = slot_q + LSLENLOG'(1);
        sym_d       = slot_wrap ? sym_q + SYMW'(1) : sym_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            key_q       <= '0;
            slot_q      <= '0;
            sym_q       <= '0;
            msg_q       <= '0;
            in_ready_q  <= 1'b0;
            msg_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_LOAD;
                        busy_q  <= 1'b1;
                    end
                end

                S_LOAD: begin
                    key_q      <= key_square;
                    msg_q      <= '0;
                    slot_q     <= '0;
                    sym_q      <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_RECV;
                end

                S_RECV: begin
                    if (accept) begin
                        if (genuine) begin
                            msg_q[int'(sym_q) * LSLENLOG +: LSLENLOG] <= in_data;
                        end
                        slot_q <= slot_d;
                        sym_q  <= sym_d;
                        if (last_accept) begin
                            in_ready_q  <= 1'b0;
                            msg_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (msg_ack) begin
                        msg_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b0;
                    msg_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign msg_valid = msg_valid_q;
    assign msg_data  = msg_q;
    assign busy      = busy_q;

endmodule
